// File: rtl/shared_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports; data wins, a streak limit guarantees fetch progress.
// Latency: IDLE sample -> BUSY (>=1 cycle, until mem_ack or watchdog) -> DONE response pulse; minimum 3 cycles.
// Backpressure: requesters hold req until their rvalid pulse; memory stalls by withholding mem_ack, bounded by the watchdog.
module shared_mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Watchdog wide enough to hold TIMEOUT_CYCLES; a zero timeout keeps a 1-bit counter that never fires.
  localparam int             WDW        = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic           WD_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [3:0]     STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t         state_q;
  logic [3:0]     streak_q;
  logic [WDW-1:0] wdog_q;

  logic        i_rvalid_q, i_err_q, d_rvalid_q, d_err_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        busy_q, timeout_flag_q;

  logic        gnt_d_d, gnt_i_d;
  logic [3:0]  streak_d;
  logic        wdog_fire_d;

  // Arbitration decision and next streak value, only consumed while IDLE.
  always_comb begin
    gnt_d_d  = 1'b0;
    gnt_i_d  = 1'b0;
    streak_d = streak_q;
    if (d_req && !(i_req && (streak_q == STREAK_MAX))) begin
      gnt_d_d = 1'b1;
    end else if (i_req) begin
      gnt_i_d = 1'b1;
    end
    if (gnt_d_d) begin
      if (!i_req) begin
        streak_d = 4'd0;
      end else if (streak_q == STREAK_MAX) begin
        streak_d = STREAK_MAX;
      end else begin
        streak_d = streak_q + 4'd1;
      end
    end else if (gnt_i_d) begin
      streak_d = 4'd0;
    end
  end

  // Watchdog fires on the last permitted BUSY cycle; mem_ack in that same cycle still wins.
  assign wdog_fire_d = WD_EN && (wdog_q == WD_LAST);

  // Main sequencer: grant in IDLE, hold the memory transaction in BUSY, pulse the response in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      streak_q       <= 4'd0;
      wdog_q         <= '0;
      i_rvalid_q     <= 1'b0;
      i_rdata_q      <= 32'd0;
      i_err_q        <= 1'b0;
      d_rvalid_q     <= 1'b0;
      d_rdata_q      <= 32'd0;
      d_err_q        <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      busy_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_d_d || gnt_i_d) begin
            streak_q  <= streak_d;
            wdog_q    <= '0;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            if (gnt_d_d) begin
              state_q     <= S_BUSY_D;
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
            end else begin
              state_q     <= S_BUSY_I;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= i_addr;
              mem_wdata_q <= 32'd0;
            end
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (mem_ack || wdog_fire_d) begin
            state_q   <= S_DONE;
            mem_req_q <= 1'b0;
            if (!mem_ack) begin
              timeout_flag_q <= 1'b1;
            end
            if (state_q == S_BUSY_D) begin
              d_rvalid_q <= 1'b1;
              d_err_q    <= !mem_ack;
              d_rdata_q  <= (mem_ack && !mem_we_q) ? mem_rdata : 32'd0;
            end else begin
              i_rvalid_q <= 1'b1;
              i_err_q    <= !mem_ack;
              i_rdata_q  <= mem_ack ? mem_rdata : 32'd0;
            end
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          i_rvalid_q <= 1'b0;
          d_rvalid_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign i_rvalid     = i_rvalid_q;
  assign i_rdata      = i_rdata_q;
  assign i_err        = i_err_q;
  assign d_rvalid     = d_rvalid_q;
  assign d_rdata      = d_rdata_q;
  assign d_err        = d_err_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed accesses, memory responder, scoreboard monitor.
// Expected memory transactions and responses are queued by stimulus, popped by the monitor.
// Memory stalls are modelled by a per-access ack delay.
module tb_shared_mem_arbiter;

  localparam logic [31:0] I_ADDR = 32'h0000_0400;
  localparam logic [31:0] D_ADDR = 32'h0000_0800;
  localparam logic [31:0] D_WD   = 32'hA1B2_C3D4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy;
  logic        timeout_flag;

  shared_mem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } mem_exp_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    logic        err;
    logic        tflag;
    int          issue_cyc;
    bit          chk_lat;
    int          lat;
  } rsp_exp_t;

  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;

  // Memory responder knobs (255 = never ack).
  int          ack_delay = 0;
  logic [31:0] rd_val    = 32'd0;
  bit          stray     = 1'b0;
  logic        exp_tflag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    assertions++;
    failures++;
    $display("FAIL %s: wait budget expired, event not seen", name);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: acks in BUSY cycle ack_delay+1, or spuriously when stray is set.
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (stray) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
      end else if (mem_req) begin
        mem_ack   = (bcnt == ack_delay);
        mem_rdata = (bcnt == ack_delay) ? rd_val : 32'd0;
        bcnt++;
      end else begin
        mem_ack = 1'b0;
        bcnt    = 0;
      end
    end
  end

  // Scoreboard monitor for both the memory side and the response side.
  initial begin
    bit          in_txn;
    bit          have_cur;
    int          blen;
    mem_exp_t    cur_mem;
    rsp_exp_t    r;
    logic [31:0] act_rdata;
    logic        act_err;
    in_txn   = 1'b0;
    have_cur = 1'b0;
    blen     = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_txn = 1'b0;
        blen   = 0;
      end else begin
        if (mem_req) begin
          if (!in_txn) begin
            in_txn   = 1'b1;
            blen     = 0;
            have_cur = (exp_mem.size() != 0);
            if (have_cur) begin
              cur_mem = exp_mem.pop_front();
            end else begin
              assertions++;
              failures++;
              $display("FAIL unexpected_mem_req: addr 0x%08h started, none expected", mem_addr);
            end
          end
          blen++;
          if (have_cur) begin
            chk("mem_addr", mem_addr, cur_mem.addr);
            chk("mem_we", 32'(mem_we), 32'(cur_mem.we));
            if (cur_mem.we) chk("mem_wdata", mem_wdata, cur_mem.wdata);
          end
        end else if (in_txn) begin
          in_txn = 1'b0;
          if (have_cur) chk("mem_req_len", 32'(blen), 32'(cur_mem.len));
        end

        if (i_rvalid || d_rvalid) begin
          chk("one_rvalid", 32'(i_rvalid & d_rvalid), 32'd0);
          if (exp_rsp.size() == 0) begin
            assertions++;
            failures++;
            $display("FAIL unexpected_rsp: i_rvalid=%0b d_rvalid=%0b, none expected", i_rvalid, d_rvalid);
          end else begin
            r         = exp_rsp.pop_front();
            act_rdata = r.is_d ? d_rdata : i_rdata;
            act_err   = r.is_d ? d_err : i_err;
            chk("rsp_port_is_d", 32'(d_rvalid), 32'(r.is_d));
            chk("rsp_rdata", act_rdata, r.rdata);
            chk("rsp_err", 32'(act_err), 32'(r.err));
            chk("timeout_flag", 32'(timeout_flag), 32'(r.tflag));
            // Latency counted inclusively: IDLE sample cycle through DONE cycle.
            if (r.chk_lat) chk("latency", 32'(cyc - r.issue_cyc + 1), 32'(r.lat));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) bound_fail("wait_idle");
  endtask

  // One access on one port; requester drops req in the cycle its response pulses.
  task automatic do_access(input bit is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay, input logic [31:0] rdval,
                           input int len, input logic [31:0] exp_rdata, input logic exp_err);
    bit seen;
    wait_idle();
    ack_delay = delay;
    rd_val    = rdval;
    exp_mem.push_back('{addr, we, wdata, len});
    exp_rsp.push_back('{is_d, exp_rdata, exp_err, exp_tflag, cyc, 1'b1, len + 2});
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = is_d ? d_rvalid : i_rvalid;
    end
    if (!seen) bound_fail("access_rsp");
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // Both requesters held; pat[n-1] is the first grant, 1 = data, 0 = fetch.
  task automatic arb_run(input int n, input logic [15:0] pat);
    int  cnt;
    bit  is_d;
    wait_idle();
    ack_delay = 0;
    rd_val    = 32'h0BAD_F00D;
    for (int k = 0; k < n; k++) begin
      is_d = pat[n-1-k];
      exp_mem.push_back('{is_d ? D_ADDR : I_ADDR, 1'b0, is_d ? D_WD : 32'd0, 1});
      exp_rsp.push_back('{is_d, rd_val, 1'b0, exp_tflag, 0, 1'b0, 0});
    end
    i_addr = I_ADDR; d_addr = D_ADDR; d_we = 1'b0; d_wdata = D_WD;
    i_req = 1'b1; d_req = 1'b1;
    cnt = 0;
    for (int k = 0; k < n * 6 + 20 && cnt < n; k++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid) cnt++;
    end
    if (cnt < n) bound_fail("arb_rsp");
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  seen;

    // Reset state.
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rvalids", 32'({i_rvalid, d_rvalid, i_err, d_err, mem_we, timeout_flag}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    #9 rst = 1'b1;

    // Single fetch with immediate ack.
    do_access(1'b0, 1'b0, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0);
    // Store acked in the 3rd BUSY cycle: response data reads as 0.
    do_access(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 2, 32'hCAFE_F00D, 3, 32'd0, 1'b0);
    // Load acked in the 2nd BUSY cycle.
    do_access(1'b1, 1'b0, 32'h0000_2004, 32'hFFFF_0000, 1, 32'h55AA_55AA, 2, 32'h55AA_55AA, 1'b0);

    // Stray mem_ack while idle must not start anything.
    wait_idle();
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_busy", 32'({busy, mem_req}), 32'd0);
    end
    stray = 1'b0;

    // Streak limit: D,D,D,D,I,D,D,D,D,I.
    arb_run(10, 16'b0000_0011_1101_1110);

    // Ack on the last watchdog cycle wins over the timeout.
    do_access(1'b1, 1'b0, 32'h0000_3000, 32'd0, 7, 32'h7777_7777, 8, 32'h7777_7777, 1'b0);
    // Hung load: aborted after 8 BUSY cycles.
    exp_tflag = 1'b1;
    do_access(1'b1, 1'b0, 32'h0000_3004, 32'd0, 255, 32'h1111_1111, 8, 32'd0, 1'b1);
    // Sticky flag persists across a normal fetch.
    do_access(1'b0, 1'b0, 32'h0000_0104, 32'd0, 0, 32'h1357_9BDF, 1, 32'h1357_9BDF, 1'b0);

    // Build a streak of 3 then hang the 3rd data access and reset mid-BUSY.
    wait_idle();
    ack_delay = 0;
    rd_val    = 32'h2468_ACE0;
    for (int k = 0; k < 3; k++) exp_mem.push_back('{D_ADDR, 1'b0, D_WD, 1});
    for (int k = 0; k < 2; k++) exp_rsp.push_back('{1'b1, rd_val, 1'b0, 1'b1, 0, 1'b0, 0});
    i_addr = I_ADDR; d_addr = D_ADDR; d_we = 1'b0; d_wdata = D_WD;
    i_req = 1'b1; d_req = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 2; k++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid) cnt++;
    end
    if (cnt < 2) bound_fail("pre_reset_rsp");
    ack_delay = 255;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = mem_req;
    end
    if (!seen) bound_fail("pre_reset_busy");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rvalids", 32'({i_rvalid, d_rvalid}), 32'd0);
    chk("midrst_tflag", 32'(timeout_flag), 32'd0);
    i_req = 1'b0;
    d_req = 1'b0;
    exp_mem.delete();
    exp_rsp.delete();
    exp_tflag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;

    // Streak must restart from 0: D,D,D,D,I.
    arb_run(5, 16'b0000_0000_0001_1110);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d failures so far", failures);
    $fatal(1, "global timeout");
  end

endmodule
